// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and frame-format helpers for the UART TX path
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic [1:0] DB_5 = 2'b00;
   localparam logic [1:0] DB_6 = 2'b01;
   localparam logic [1:0] DB_7 = 2'b10;
   localparam logic [1:0] DB_8 = 2'b11;

   function automatic logic [3:0] nbits(input logic [1:0] data_bits);
      return 4'd5 + {2'b00, data_bits};
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
      logic [7:0] m;
      case (data_bits)
         DB_5:    m = 8'h1F;
         DB_6:    m = 8'h3F;
         DB_7:    m = 8'h7F;
         DB_8:    m = 8'hFF;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - bus-side push, configuration and status bundle of the UART TX engine
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             wr_en;
   logic [7:0]       wr_data;
   logic [DIV_W-1:0] divisor;
   logic [1:0]       data_bits;
   logic             parity_en;
   logic             parity_odd;
   logic             two_stop;
   logic             tx_en;
   logic [1:0]       irq_en;
   logic [1:0]       irq_clr;

   logic             busy;
   logic             full;
   logic [LVL_W-1:0] level;
   logic             done_flag;
   logic             ovf_flag;
   logic             interrupt;

   modport master (
      output wr_en, wr_data, divisor, data_bits, parity_en, parity_odd,
             two_stop, tx_en, irq_en, irq_clr,
      input  busy, full, level, done_flag, ovf_flag, interrupt
   );

   modport slave (
      input  wr_en, wr_data, divisor, data_bits, parity_en, parity_odd,
             two_stop, tx_en, irq_en, irq_clr,
      output busy, full, level, done_flag, ovf_flag, interrupt
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; shared by the TX and RX paths
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     nRst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count == LW'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with runtime baud divisor and frame format
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic          clock,
   input  logic          nRst,
   uart_tx_fifo_if.slave bus,
   output logic          TX
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   tx_state_t        state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [DIV_W-1:0] div_q, div_n;
   logic [7:0]       shift, shift_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [3:0]       nbits_q, nbits_n;
   logic             par_en_q, par_en_n;
   logic             par_bit_q, par_bit_n;
   logic             two_stop_q, two_stop_n;
   logic             stop_idx, stop_idx_n;
   logic             done_q, ovf_q;

   logic             pop;
   logic             bit_tick;
   logic             push_ok;
   logic             done_set;
   logic             ovf_set;
   logic [7:0]       fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] fifo_level;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .nRst      (nRst),
      .push      (bus.wr_en),
      .push_data (bus.wr_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign bit_tick = (cnt == div_q);
   assign push_ok  = bus.wr_en & ~fifo_full;
   assign ovf_set  = bus.wr_en & fifo_full;
   assign done_set = (state == STOP) && (state_n == IDLE) && fifo_empty && !push_ok;

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         state      <= IDLE;
         cnt        <= '0;
         div_q      <= '0;
         shift      <= '0;
         bit_idx    <= '0;
         nbits_q    <= 4'd8;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop_idx   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         div_q      <= div_n;
         shift      <= shift_n;
         bit_idx    <= bit_idx_n;
         nbits_q    <= nbits_n;
         par_en_q   <= par_en_n;
         par_bit_q  <= par_bit_n;
         two_stop_q <= two_stop_n;
         stop_idx   <= stop_idx_n;
      end
   end

   // The whole frame format is captured at pop so bus-side changes only hit the next frame.
   always_comb begin
      state_n    = state;
      cnt_n      = bit_tick ? '0 : cnt + 1'b1;
      div_n      = div_q;
      shift_n    = shift;
      bit_idx_n  = bit_idx;
      nbits_n    = nbits_q;
      par_en_n   = par_en_q;
      par_bit_n  = par_bit_q;
      two_stop_n = two_stop_q;
      stop_idx_n = stop_idx;
      pop        = 1'b0;
      TX         = 1'b1;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (bus.tx_en && !fifo_empty) begin
               pop        = 1'b1;
               shift_n    = fifo_head;
               div_n      = bus.divisor;
               nbits_n    = nbits(bus.data_bits);
               par_en_n   = bus.parity_en;
               par_bit_n  = (^(fifo_head & data_mask(bus.data_bits))) ^ bus.parity_odd;
               two_stop_n = bus.two_stop;
               state_n    = START;
            end
         end
         START: begin
            TX = 1'b0;
            if (bit_tick) begin
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            TX = shift[0];
            if (bit_tick) begin
               shift_n = {1'b0, shift[7:1]};
               if ({1'b0, bit_idx} == nbits_q - 4'd1) begin
                  stop_idx_n = 1'b0;
                  state_n    = par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         PARITY: begin
            TX = par_bit_q;
            if (bit_tick) begin
               stop_idx_n = 1'b0;
               state_n    = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (two_stop_q && !stop_idx) stop_idx_n = 1'b1;
               else                         state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (done_set)            done_q <= 1'b1;
         else if (bus.irq_clr[0]) done_q <= 1'b0;
         if (ovf_set)             ovf_q  <= 1'b1;
         else if (bus.irq_clr[1]) ovf_q  <= 1'b0;
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.full      = fifo_full;
   assign bus.level     = fifo_level;
   assign bus.done_flag = done_q;
   assign bus.ovf_flag  = ovf_q;
   assign bus.interrupt = (done_q & bus.irq_en[0]) | (ovf_q & bus.irq_en[1]);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int DW    = 16;

   logic clock = 1'b0;
   logic nRst  = 1'b0;
   logic tx;

   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) bus ();

   uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
      .clock (clock),
      .nRst  (nRst),
      .bus   (bus),
      .TX    (tx)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] div;
      logic [1:0]  db;
      logic        pe;
      logic        po;
      logic        two;
   } cfg_t;

   typedef struct {
      logic [7:0] data;
      cfg_t       cfg;
      int         exp_len;
      int         exp_par;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_w[$];
   logic cap_w[$];
   int   cap_gap;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input cfg_t c);
      bus.divisor    = c.div;
      bus.data_bits  = c.db;
      bus.parity_en  = c.pe;
      bus.parity_odd = c.po;
      bus.two_stop   = c.two;
   endtask

   task automatic write_byte(input logic [7:0] d);
      bus.wr_data = d;
      bus.wr_en   = 1'b1;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic clear_flags();
      bus.irq_clr = 2'b11;
      tick();
      bus.irq_clr = 2'b00;
   endtask

   // Reference waveform: start, LSB-first data, optional parity, stops; each symbol div+1 clocks.
   task automatic build_wave(input logic [7:0] b, input cfg_t c);
      logic sym[$];
      int   n;
      int   ones;
      exp_w.delete();
      n    = 5 + int'(c.db);
      ones = 0;
      sym.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         sym.push_back(b[i]);
         if (b[i]) ones++;
      end
      if (c.pe) sym.push_back(((ones % 2) == 1) ^ c.po);
      sym.push_back(1'b1);
      if (c.two) sym.push_back(1'b1);
      foreach (sym[k])
         for (int r = 0; r <= int'(c.div); r++) exp_w.push_back(sym[k]);
   endtask

   task automatic get_frame(input int limit);
      cap_w.delete();
      cap_gap = 0;
      while (bus.busy !== 1'b1 && cap_gap < limit) begin
         cap_gap++;
         tick();
      end
      if (bus.busy !== 1'b1) begin
         check("frame_start_timeout", bus.busy, 1);
         return;
      end
      while (bus.busy === 1'b1 && cap_w.size() < 4000) begin
         cap_w.push_back(tx);
         tick();
      end
   endtask

   task automatic compare_wave(input string name);
      int bad;
      bad = -1;
      n_checks++;
      if (cap_w.size() == exp_w.size()) begin
         foreach (exp_w[i])
            if (bad < 0 && cap_w[i] !== exp_w[i]) bad = i;
      end
      if (cap_w.size() != exp_w.size() || bad >= 0) begin
         n_fail++;
         $display("FAIL %s: got %0d clks (first bad clk %0d), want %0d clks",
                  name, cap_w.size(), bad, exp_w.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt[6];
      cfg_t       c;
      cfg_t       c2;
      logic [7:0] mq[$];
      int         busy_cnt;
      int         nb;
      int         pidx;
      int         k;

      bus.wr_en = 1'b0; bus.wr_data = '0; bus.divisor = '0; bus.data_bits = 2'b11;
      bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.two_stop = 1'b0;
      bus.tx_en = 1'b0; bus.irq_en = 2'b00; bus.irq_clr = 2'b00;

      repeat (3) @(posedge clock);
      #1;
      check("rst_tx", tx, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_full", bus.full, 0);
      check("rst_level", bus.level, 0);
      check("rst_done", bus.done_flag, 0);
      check("rst_ovf", bus.ovf_flag, 0);
      check("rst_irq", bus.interrupt, 0);
      nRst = 1'b1;
      tick();

      vt[0] = '{8'hA5, '{16'd3, 2'b11, 1'b0, 1'b0, 1'b0}, 40, -1};
      vt[1] = '{8'h55, '{16'd0, 2'b10, 1'b1, 1'b0, 1'b1}, 11,  0};
      vt[2] = '{8'h1F, '{16'd1, 2'b00, 1'b1, 1'b1, 1'b0}, 16,  0};
      vt[3] = '{8'h1E, '{16'd1, 2'b00, 1'b1, 1'b1, 1'b0}, 16,  1};
      vt[4] = '{8'h3C, '{16'd2, 2'b01, 1'b1, 1'b0, 1'b0}, 27,  0};
      vt[5] = '{8'h00, '{16'd0, 2'b11, 1'b1, 1'b1, 1'b1}, 12,  1};

      bus.irq_en = 2'b01;
      bus.tx_en  = 1'b1;
      foreach (vt[v]) begin
         set_cfg(vt[v].cfg);
         clear_flags();
         write_byte(vt[v].data);
         check("lat_level", bus.level, 1);
         check("lat_tx_idle", tx, 1);
         tick();
         check("lat_tx_low", tx, 0);
         check("lat_pop_level", bus.level, 0);
         get_frame(4);
         build_wave(vt[v].data, vt[v].cfg);
         compare_wave("vec_wave");
         check("vec_len", cap_w.size(), vt[v].exp_len);
         if (vt[v].exp_par >= 0) begin
            pidx = (6 + int'(vt[v].cfg.db)) * (int'(vt[v].cfg.div) + 1);
            if (pidx < cap_w.size()) check("vec_parity", cap_w[pidx], vt[v].exp_par);
            else                     check("vec_parity_pos", cap_w.size(), pidx + 1);
         end
         check("vec_done", bus.done_flag, 1);
         check("vec_irq", bus.interrupt, 1);
      end

      // Overflow with transmitter held off, then drain back-to-back.
      c = '{16'd0, 2'b11, 1'b0, 1'b0, 1'b0};
      set_cfg(c);
      bus.tx_en  = 1'b0;
      bus.irq_en = 2'b10;
      clear_flags();
      mq.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         bus.wr_data = 8'($urandom_range(0, 255));
         bus.wr_en   = 1'b1;
         if (mq.size() < DEPTH) mq.push_back(bus.wr_data);
         tick();
      end
      bus.wr_en = 1'b0;
      check("ovf_level", bus.level, DEPTH);
      check("ovf_full", bus.full, 1);
      check("ovf_flag", bus.ovf_flag, 1);
      check("ovf_irq", bus.interrupt, 1);
      bus.irq_clr = 2'b10;
      tick();
      bus.irq_clr = 2'b00;
      check("ovf_clr_flag", bus.ovf_flag, 0);
      check("ovf_clr_irq", bus.interrupt, 0);
      check("ovf_clr_level", bus.level, DEPTH);
      bus.tx_en = 1'b1;
      for (int f = 0; f < DEPTH; f++) begin
         get_frame(8);
         build_wave(mq[f], c);
         compare_wave("drain_wave");
         if (f > 0)  check("drain_gap", cap_gap, 1);
         if (f == 0) check("drain_not_done", bus.done_flag, 0);
      end
      check("drain_done", bus.done_flag, 1);
      check("drain_level", bus.level, 0);

      // Random formats and bytes against the frame model.
      bus.irq_en = 2'b01;
      for (int b = 0; b < 6; b++) begin
         c.div = 16'($urandom_range(0, 3));
         c.db  = 2'($urandom_range(0, 3));
         c.pe  = 1'($urandom_range(0, 1));
         c.po  = 1'($urandom_range(0, 1));
         c.two = 1'($urandom_range(0, 1));
         set_cfg(c);
         bus.tx_en = 1'b0;
         clear_flags();
         nb = $urandom_range(1, 4);
         mq.delete();
         for (int i = 0; i < nb; i++) begin
            mq.push_back(8'($urandom_range(0, 255)));
            write_byte(mq[i]);
         end
         check("rnd_level", bus.level, nb);
         bus.tx_en = 1'b1;
         for (int i = 0; i < nb; i++) begin
            get_frame(8);
            build_wave(mq[i], c);
            compare_wave("rnd_wave");
         end
         check("rnd_done", bus.done_flag, 1);
      end

      // Reset in the middle of the second of three frames.
      c = '{16'd3, 2'b11, 1'b0, 1'b0, 1'b0};
      set_cfg(c);
      bus.tx_en = 1'b0;
      clear_flags();
      mq.delete();
      for (int i = 0; i < 3; i++) begin
         mq.push_back(8'($urandom_range(0, 255)));
         write_byte(mq[i]);
      end
      bus.tx_en = 1'b1;
      get_frame(8);
      build_wave(mq[0], c);
      compare_wave("rst_frame1");
      k = 0;
      while (bus.busy !== 1'b1 && k < 8) begin
         k++;
         tick();
      end
      repeat (8) tick();
      check("mid_busy", bus.busy, 1);
      check("mid_level", bus.level, 1);
      @(posedge clock);
      #3;
      nRst = 1'b0;
      #1;
      check("async_rst_tx", tx, 1);
      check("async_rst_level", bus.level, 0);
      check("async_rst_busy", bus.busy, 0);
      tick();
      tick();
      nRst = 1'b1;
      busy_cnt = 0;
      repeat (20) begin
         tick();
         if (bus.busy) busy_cnt++;
      end
      check("post_rst_idle", busy_cnt, 0);
      write_byte(8'h3A);
      get_frame(4);
      build_wave(8'h3A, c);
      compare_wave("post_rst_frame");

      // Divisor change mid-frame and tx_en drop during the following frame.
      set_cfg(c);
      bus.tx_en = 1'b0;
      clear_flags();
      mq.delete();
      for (int i = 0; i < 3; i++) begin
         mq.push_back(8'($urandom_range(0, 255)));
         write_byte(mq[i]);
      end
      bus.tx_en = 1'b1;
      c2     = c;
      c2.div = 16'd7;
      fork
         begin
            get_frame(8);
            build_wave(mq[0], c);
            compare_wave("div_keep");
            get_frame(8);
            build_wave(mq[1], c2);
            compare_wave("div_next");
         end
         begin
            repeat (10) tick();
            bus.divisor = 16'd7;
            repeat (55) tick();
            bus.tx_en = 1'b0;
         end
      join
      check("halt_level", bus.level, 1);
      busy_cnt = 0;
      repeat (30) begin
         tick();
         if (bus.busy) busy_cnt++;
      end
      check("halt_idle", busy_cnt, 0);
      check("halt_level_hold", bus.level, 1);
      check("halt_not_done", bus.done_flag, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
